// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core: widths, opcodes and the
// fetch FSM state encoding.
package cpu_pkg;

    localparam int XLEN     = 32;
    localparam int OPCODE_W = 6;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    // Word offset of a branch immediate, as a byte offset.
    function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken beq target, or pc+4.
// Jump wins over branch when both are asserted.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [25:0]     imm26_i,
    input  logic            branch_i,
    input  logic            jump_i,
    input  logic            zero_i,
    output logic [XLEN-1:0] next_pc_o
);

    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jump_target;

    always_comb begin
        branch_target = pc_plus4_i + branch_offset(imm26_i[15:0]);
        jump_target   = {pc_plus4_i[31:28], imm26_i, 2'b00};
        next_pc_o     = pc_plus4_i;
        if (jump_i) begin
            next_pc_o = jump_target;
        end else if (branch_i && zero_i) begin
            next_pc_o = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per retire from a
// variable-latency memory. Optional stall counter under FETCH_STALL_CNT_EN.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic [XLEN-1:0]     instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic                instr_valid,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    input  logic                retire,
    input  logic                branch,
    input  logic                jump,
    input  logic                zero,
`ifdef FETCH_STALL_CNT_EN
    output logic [XLEN-1:0]     stall_cnt,
`endif
    output fetch_state_t        state_dbg
);

    // Memory handshake: a request is accepted when imem_req & imem_ready are
    // both high at a rising edge; exactly one word returns later on imem_rvalid.
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_plus4_w;
    logic [XLEN-1:0] next_pc;

    assign pc_plus4_w = pc_q + 32'd4;

    next_pc_calc u_next_pc (
        .pc_plus4_i (pc_plus4_w),
        .imm26_i    (instr_q[25:0]),
        .branch_i   (branch),
        .jump_i     (jump),
        .zero_i     (zero),
        .next_pc_o  (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            S_REQ: begin
                if (imem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (retire) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Reset abandons any outstanding request; memory discards it on the same reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign state_dbg   = state_q;

`ifdef FETCH_STALL_CNT_EN
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
    logic            stalled;

    always_comb begin
        stalled     = ((state_q == S_REQ) && !imem_ready) ||
                      ((state_q == S_WAIT) && !imem_rvalid);
        stall_cnt_d = stall_cnt_q;
        if (stalled && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
